// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - operand-pair sequencer for the MAC stage
// Feeds accepted pairs to the MAC, drains its output pipeline, returns the result and clears the accumulator.
module mac_feeder #(
   parameter int WIDTH         = 8,
   parameter int ACCUMULATIONS = 3,
   parameter int DRAIN_CYCLES  = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_last,
   output logic             mac_enable,
   output logic [WIDTH-1:0] mac_a,
   output logic [WIDTH-1:0] mac_b,
   output logic             mac_clear,
   input  logic [WIDTH-1:0] mac_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             overflow,
   output logic             busy
);

   localparam int CW = $clog2(ACCUMULATIONS + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_CAPTURE,
      S_RESULT,
      S_CLEAR
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_pair_cnt;
   logic [DW-1:0]    r_drain_cnt;
   logic             r_mac_enable;
   logic [WIDTH-1:0] r_mac_a;
   logic [WIDTH-1:0] r_mac_b;
   logic [WIDTH-1:0] r_out_data;
   logic             r_overflow;

   logic w_accept;
   logic w_pair_full;
   logic w_end_vec;
   logic w_drain_done;

   // in_ready is forced low while reset is held so every output reads 0 during reset
   assign in_ready     = reset_n && ((r_state == S_IDLE) || (r_state == S_ACCUM));
   assign w_accept     = in_valid && in_ready;
   assign w_pair_full  = (r_pair_cnt == CW'(ACCUMULATIONS - 1));
   assign w_end_vec    = w_accept && (in_last || w_pair_full);
   assign w_drain_done = (r_drain_cnt == DW'(DRAIN_CYCLES));

   assign mac_enable = r_mac_enable;
   assign mac_a      = r_mac_a;
   assign mac_b      = r_mac_b;
   assign out_data   = r_out_data;
   assign overflow   = r_overflow;
   assign out_valid  = (r_state == S_RESULT);
   assign mac_clear  = (r_state == S_CLEAR);
   assign busy       = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_ACCUM: begin
            if (w_end_vec) begin
               w_next = S_DRAIN;
            end else if (w_accept) begin
               w_next = S_ACCUM;
            end
         end
         S_DRAIN: begin
            if (w_drain_done) begin
               w_next = S_CAPTURE;
            end
         end
         S_CAPTURE: w_next = S_RESULT;
         S_RESULT: begin
            if (out_ready) begin
               w_next = S_CLEAR;
            end
         end
         S_CLEAR: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // DRAIN lasts DRAIN_CYCLES+1 cycles: the first still shows the last operand pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pair_cnt   <= '0;
         r_drain_cnt  <= '0;
         r_mac_enable <= 1'b0;
         r_mac_a      <= '0;
         r_mac_b      <= '0;
         r_out_data   <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_mac_enable <= 1'b0;
         r_mac_a      <= '0;
         r_mac_b      <= '0;
         if (w_accept) begin
            r_mac_enable <= 1'b1;
            r_mac_a      <= in_a;
            r_mac_b      <= in_b;
            r_pair_cnt   <= r_pair_cnt + CW'(1);
            if (w_pair_full && !in_last) begin
               r_overflow <= 1'b1;
            end
         end
         if ((r_state == S_DRAIN) && !w_drain_done) begin
            r_mac_enable <= 1'b1;
            r_drain_cnt  <= r_drain_cnt + DW'(1);
         end
         if (r_state == S_CAPTURE) begin
            r_out_data <= mac_out;
         end
         if (r_state == S_CLEAR) begin
            r_pair_cnt  <= '0;
            r_drain_cnt <= '0;
            r_overflow  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder
// Event-schedule reference model plus a directed table and corner-case sequences.
module tb_mac_feeder;

   localparam int W = 8;
   localparam int A = 3;
   localparam int D = 2;
   localparam int N = 1024;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] mac_out = '0;
   logic         in_ready, mac_enable, mac_clear, out_valid, overflow, busy;
   logic [W-1:0] mac_a, mac_b, out_data;

   always #5 clk = ~clk;

   mac_feeder #(.WIDTH(W), .ACCUMULATIONS(A), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear),
      .mac_out(mac_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .overflow(overflow), .busy(busy)
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: expected MAC pulses are scheduled by absolute cycle number
   int           cyc;
   bit           en_q [N];
   logic [W-1:0] a_q [N];
   logic [W-1:0] b_q [N];
   logic [W-1:0] mo_h [N];
   int           m_cnt, m_first, m_end, m_hs;
   bit           m_open, m_ovf;
   logic [W-1:0] m_data;
   int           acc_log [$];

   typedef struct {
      bit           v;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           l;
      bit           rdy;
      logic [28:0]  exp;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         en_q[i] = 1'b0;
         a_q[i]  = '0;
         b_q[i]  = '0;
         mo_h[i] = '0;
      end
      cyc = 0;
      m_cnt = 0;
      m_first = -1;
      m_end = -1;
      m_hs = -1;
      m_open = 1'b1;
      m_ovf = 1'b0;
      m_data = '0;
      acc_log.delete();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      mac_out = '0;
      reset_n = 1'b0;
      #1;
      chk("reset_outputs", int'({in_ready, mac_enable, mac_a, mac_b, mac_clear,
                                 out_valid, out_data, overflow, busy}), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   // Called at posedge+1: check this cycle against the model, drive inputs, advance
   task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit l, input bit rdy, input logic [W-1:0] mo);
      bit e_valid;
      if (cyc + D + 3 >= N) begin
         $display("FAIL cycle_budget cyc=%0d got=%0d expected<%0d", cyc, cyc, N - D - 3);
         $fatal(1);
      end
      if (m_hs >= 0 && cyc == m_hs + 2) begin
         m_open = 1'b1;
         m_cnt = 0;
         m_first = -1;
         m_end = -1;
         m_hs = -1;
         m_ovf = 1'b0;
      end
      e_valid = (m_end >= 0) && (m_hs < 0) && (cyc >= m_end + 3 + D);
      if (m_end >= 0 && cyc == m_end + 3 + D) m_data = mo_h[m_end + 2 + D];
      chk("in_ready",   in_ready,   m_open);
      chk("mac_enable", mac_enable, en_q[cyc]);
      chk("mac_a",      mac_a,      a_q[cyc]);
      chk("mac_b",      mac_b,      b_q[cyc]);
      chk("mac_clear",  mac_clear,  (m_hs >= 0) && (cyc == m_hs + 1));
      chk("out_valid",  out_valid,  e_valid);
      chk("out_data",   out_data,   m_data);
      chk("overflow",   overflow,   m_ovf && (cyc > m_end));
      chk("busy",       busy,       (m_first >= 0) && (cyc > m_first));
      in_valid = v;
      in_a = a;
      in_b = b;
      in_last = l;
      out_ready = rdy;
      mac_out = mo;
      mo_h[cyc] = mo;
      if (in_ready && v) acc_log.push_back(cyc);
      if (m_open && v) begin
         en_q[cyc + 1] = 1'b1;
         a_q[cyc + 1] = a;
         b_q[cyc + 1] = b;
         if (m_first < 0) m_first = cyc;
         m_cnt++;
         if (l || m_cnt == A) begin
            m_end = cyc;
            m_open = 1'b0;
            m_ovf = !l;
            for (int d = 0; d < D; d++) en_q[cyc + 2 + d] = 1'b1;
         end
      end
      if (e_valid && rdy) m_hs = cyc;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, rdy, 8'h5A);
   endtask

   initial begin
      // expected = {in_ready, mac_enable, mac_a, mac_b, mac_clear, out_valid, out_data, busy}
      tbl[0] = '{1'b1, 8'h02, 8'h03, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}};
      tbl[1] = '{1'b1, 8'h04, 8'h05, 1'b1, 1'b1, {1'b1, 1'b1, 8'h02, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1}};
      tbl[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 1'b1, 8'h04, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1}};
      tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}};
      tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}};
      tbl[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}};
      tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1}};
      tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1}};
      tbl[8] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0}};

      do_reset();

      // Two-pair vector, back-to-back beats, explicit per-cycle expectations
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("table_row%0d", i),
             int'({in_ready, mac_enable, mac_a, mac_b, mac_clear, out_valid, out_data, busy}),
             int'(tbl[i].exp));
         step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].rdy, 8'h5A);
      end

      // Asynchronous reset while draining: outputs drop without a clock edge
      step(1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 8'h5A);
      idle(2, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_mid_drain",
          int'({in_ready, mac_enable, mac_a, mac_b, mac_clear, out_valid, out_data, overflow, busy}), 0);
      do_reset();

      // Gapped beats
      step(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h33);
      idle(2, 1'b1);
      step(1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 8'h77);
      idle(10, 1'b1);

      // Truncation: in_valid held high with in_last=0
      acc_log.delete();
      for (int i = 0; i < 14; i++) step(1'b1, 8'(i + 1), 8'(i + 2), 1'b0, 1'b1, 8'(8'hC0 + i));
      idle(10, 1'b1);
      if (acc_log.size() >= 4) chk("overflow_4th_beat_delay", acc_log[3] - acc_log[0], A - 1 + D + 5);
      else chk("overflow_accept_count", acc_log.size(), 4);

      // Result stall with out_ready low
      step(1'b1, 8'h0A, 8'h0B, 1'b1, 1'b0, 8'h3C);
      idle(D + 3 + 10, 1'b0);
      chk("stall_valid_held", out_valid, 1);
      idle(4, 1'b1);

      // Single-pair vectors at minimum period
      acc_log.delete();
      for (int i = 0; i < 10; i++) step(1'b1, 8'h07, 8'h09, 1'b1, 1'b1, 8'(8'h40 + i));
      idle(8, 1'b1);
      if (acc_log.size() >= 2) chk("single_pair_period", acc_log[1] - acc_log[0], D + 5);
      else chk("single_pair_accept_count", acc_log.size(), 2);

      // Randomised traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
